// File: rtl/clock_pkg.sv
// Shared types and digit rules for the front-panel time editor.
// Holds the edit state enum, field indices, digit limits and helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SET_TIME,
    ST_SET_ALARM
  } state_t;

  localparam logic [2:0] F_HOUR_SHI = 3'd0;
  localparam logic [2:0] F_HOUR_GE  = 3'd1;
  localparam logic [2:0] F_MIN_SHI  = 3'd2;
  localparam logic [2:0] F_MIN_GE   = 3'd3;
  localparam logic [2:0] F_SEC_SHI  = 3'd4;
  localparam logic [2:0] F_SEC_GE   = 3'd5;

  localparam logic [3:0] HOUR_SHI_MAX     = 4'd2;
  localparam logic [3:0] HOUR_GE_MAX_AT_2 = 4'd3;
  localparam logic [3:0] SHI_MAX          = 4'd5;
  localparam logic [3:0] GE_MAX           = 4'd9;

  // Index 0 is hour_shi, 5 is sec_ge (same as field order).
  typedef logic [5:0][3:0] digits_t;
  typedef logic [3:0][3:0] alarm_t;

  function automatic logic [3:0] digit_max(
    input logic [2:0] f,
    input logic [3:0] hour_shi
  );
    logic [3:0] m;
    unique case (f)
      F_HOUR_SHI: m = HOUR_SHI_MAX;
      F_HOUR_GE:
        m = (hour_shi == HOUR_SHI_MAX) ?
            HOUR_GE_MAX_AT_2 : GE_MAX;
      F_MIN_SHI,
      F_SEC_SHI:  m = SHI_MAX;
      default:    m = GE_MAX;
    endcase
    return m;
  endfunction

  // hour_shi is clamped first so hour_ge sees its final value.
  function automatic digits_t clamp_digits(
    input digits_t d
  );
    digits_t    r;
    logic [3:0] m;
    r = d;
    for (int i = 0; i < 6; i++) begin
      m    = digit_max(3'(i), r[0]);
      r[i] = (d[i] > m) ? m : d[i];
    end
    return r;
  endfunction

  function automatic digits_t inc_digit(
    input digits_t    d,
    input logic [2:0] f
  );
    digits_t    r;
    logic [3:0] m;
    r = d;
    if (f <= F_SEC_GE) begin
      m    = digit_max(f, d[0]);
      r[f] = (d[f] >= m) ? 4'd0 : d[f] + 4'd1;
      if (f == F_HOUR_SHI &&
          r[0] == HOUR_SHI_MAX &&
          r[1] > HOUR_GE_MAX_AT_2)
        r[1] = HOUR_GE_MAX_AT_2;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser and debouncer producing one pulse per accepted press.
// Ports: clk, rst, key_n (raw active-low key), press (1-cycle pulse).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW =
    $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // stable_q flips only after the synced level has differed
  // from it for DEBOUNCE_CYCLES consecutive cycles; a press
  // pulse is emitted only on the high-to-low flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time/alarm editor: keys in, committed digits out.
// Ports: keys, cur_* time in; set_*, strobe, clock_*, status out.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_ok_n,
  input  logic       key_alarm_n,
  input  logic [3:0] cur_sec_ge,
  input  logic [3:0] cur_sec_shi,
  input  logic [3:0] cur_min_ge,
  input  logic [3:0] cur_min_shi,
  input  logic [3:0] cur_hour_ge,
  input  logic [3:0] cur_hour_shi,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       set_time_finish,
  output logic [3:0] clock_min_ge,
  output logic [3:0] clock_min_shi,
  output logic [3:0] clock_hour_ge,
  output logic [3:0] clock_hour_shi,
  output logic       clock_en,
  output logic       editing,
  output logic       edit_alarm,
  output logic [2:0] edit_field
);

  localparam int unsigned TW =
    $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic mode_p;
  logic inc_p;
  logic ok_p;
  logic alarm_p;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_mode (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_mode_n),
    .press(mode_p)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_inc (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_inc_n),
    .press(inc_p)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_ok (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_ok_n),
    .press(ok_p)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_alarm (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_alarm_n),
    .press(alarm_p)
  );

  state_t        state_q, state_d;
  logic [2:0]    field_q, field_d;
  digits_t       edit_q, edit_d;
  digits_t       set_q, set_d;
  alarm_t        alarm_q, alarm_d;
  logic          en_q, en_d;
  logic          fin_q, fin_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          editing_q;
  logic          edit_alarm_q;
  digits_t       cur_dig;
  logic          any_p;
  logic          tmo;

  assign cur_dig = {cur_sec_ge, cur_sec_shi,
                    cur_min_ge, cur_min_shi,
                    cur_hour_ge, cur_hour_shi};

  // Pulse priority ok > mode > inc; alarm toggles on its own.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    edit_d  = edit_q;
    set_d   = set_q;
    alarm_d = alarm_q;
    fin_d   = 1'b0;
    en_d    = en_q ^ alarm_p;
    any_p   = mode_p | inc_p | ok_p | alarm_p;
    tmo     = (tcnt_q == T_LAST) && !alarm_p;
    unique case (state_q)
      ST_IDLE: begin
        if (!ok_p && mode_p) begin
          state_d = ST_SET_TIME;
          field_d = F_HOUR_SHI;
          edit_d  = clamp_digits(cur_dig);
        end
      end
      ST_SET_TIME: begin
        if (ok_p) begin
          set_d   = edit_q;
          fin_d   = 1'b1;
          state_d = ST_IDLE;
          field_d = F_HOUR_SHI;
        end else if (mode_p) begin
          if (field_q == F_SEC_GE) begin
            state_d = ST_SET_ALARM;
            field_d = F_HOUR_SHI;
            edit_d  = {8'h00, alarm_q};
          end else begin
            field_d = field_q + 3'd1;
          end
        end else if (inc_p) begin
          edit_d = inc_digit(edit_q, field_q);
        end else if (tmo) begin
          state_d = ST_IDLE;
          field_d = F_HOUR_SHI;
        end
      end
      ST_SET_ALARM: begin
        if (ok_p) begin
          alarm_d = edit_q[3:0];
          state_d = ST_IDLE;
          field_d = F_HOUR_SHI;
        end else if (mode_p) begin
          if (field_q == F_MIN_GE) begin
            state_d = ST_IDLE;
            field_d = F_HOUR_SHI;
          end else begin
            field_d = field_q + 3'd1;
          end
        end else if (inc_p) begin
          edit_d = inc_digit(edit_q, field_q);
        end else if (tmo) begin
          state_d = ST_IDLE;
          field_d = F_HOUR_SHI;
        end
      end
      default: begin
        state_d = ST_IDLE;
        field_d = F_HOUR_SHI;
      end
    endcase
    // Idle time only counts inside an edit state.
    if (state_d != state_q || any_p ||
        state_q == ST_IDLE)
      tcnt_d = '0;
    else
      tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      field_q      <= F_HOUR_SHI;
      edit_q       <= '0;
      set_q        <= '0;
      alarm_q      <= '0;
      en_q         <= 1'b0;
      fin_q        <= 1'b0;
      tcnt_q       <= '0;
      editing_q    <= 1'b0;
      edit_alarm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      edit_q       <= edit_d;
      set_q        <= set_d;
      alarm_q      <= alarm_d;
      en_q         <= en_d;
      fin_q        <= fin_d;
      tcnt_q       <= tcnt_d;
      editing_q    <= (state_d != ST_IDLE);
      edit_alarm_q <= (state_d == ST_SET_ALARM);
    end
  end

  assign set_hour_shi    = set_q[F_HOUR_SHI];
  assign set_hour_ge     = set_q[F_HOUR_GE];
  assign set_min_shi     = set_q[F_MIN_SHI];
  assign set_min_ge      = set_q[F_MIN_GE];
  assign set_sec_shi     = set_q[F_SEC_SHI];
  assign set_sec_ge      = set_q[F_SEC_GE];
  assign set_time_finish = fin_q;
  assign clock_hour_shi  = alarm_q[F_HOUR_SHI];
  assign clock_hour_ge   = alarm_q[F_HOUR_GE];
  assign clock_min_shi   = alarm_q[F_MIN_SHI];
  assign clock_min_ge    = alarm_q[F_MIN_GE];
  assign clock_en        = en_q;
  assign editing         = editing_q;
  assign edit_alarm      = edit_alarm_q;
  assign edit_field      = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl against a digit-level model.
// Directed front-panel scenarios followed by random key sequences.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode_n, key_inc_n;
  logic       key_ok_n, key_alarm_n;
  logic [3:0] cur_sec_ge, cur_sec_shi;
  logic [3:0] cur_min_ge, cur_min_shi;
  logic [3:0] cur_hour_ge, cur_hour_shi;
  logic [3:0] set_sec_ge, set_sec_shi;
  logic [3:0] set_min_ge, set_min_shi;
  logic [3:0] set_hour_ge, set_hour_shi;
  logic       set_time_finish;
  logic [3:0] clock_min_ge, clock_min_shi;
  logic [3:0] clock_hour_ge, clock_hour_shi;
  logic       clock_en, editing, edit_alarm;
  logic [2:0] edit_field;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_mode_n     (key_mode_n),
    .key_inc_n      (key_inc_n),
    .key_ok_n       (key_ok_n),
    .key_alarm_n    (key_alarm_n),
    .cur_sec_ge     (cur_sec_ge),
    .cur_sec_shi    (cur_sec_shi),
    .cur_min_ge     (cur_min_ge),
    .cur_min_shi    (cur_min_shi),
    .cur_hour_ge    (cur_hour_ge),
    .cur_hour_shi   (cur_hour_shi),
    .set_sec_ge     (set_sec_ge),
    .set_sec_shi    (set_sec_shi),
    .set_min_ge     (set_min_ge),
    .set_min_shi    (set_min_shi),
    .set_hour_ge    (set_hour_ge),
    .set_hour_shi   (set_hour_shi),
    .set_time_finish(set_time_finish),
    .clock_min_ge   (clock_min_ge),
    .clock_min_shi  (clock_min_shi),
    .clock_hour_ge  (clock_hour_ge),
    .clock_hour_shi (clock_hour_shi),
    .clock_en       (clock_en),
    .editing        (editing),
    .edit_alarm     (edit_alarm),
    .edit_field     (edit_field)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  logic [23:0] got_set;
  logic [15:0] got_alm;
  assign got_set = {set_hour_shi, set_hour_ge,
                    set_min_shi, set_min_ge,
                    set_sec_shi, set_sec_ge};
  assign got_alm = {clock_hour_shi, clock_hour_ge,
                    clock_min_shi, clock_min_ge};

  // Strobe monitor: count strobes, catch double-width pulses,
  // and record set_* at the strobe and just before it.
  int          strobes = 0;
  bit          dbl = 0;
  logic        fin_prev = 1'b0;
  logic [23:0] pre_set = '0;
  logic [23:0] strobe_set = '0;
  logic [23:0] strobe_pre = '0;
  always @(negedge clk) begin
    if (set_time_finish === 1'b1) begin
      strobes++;
      strobe_set = got_set;
      strobe_pre = pre_set;
      if (fin_prev) dbl = 1;
    end else begin
      pre_set = got_set;
    end
    fin_prev = set_time_finish;
  end

  // Reference model: 0 idle, 1 time edit, 2 alarm edit.
  int m_st, m_f, m_strobes;
  int m_ed[6], m_set[6], m_alm[4], m_cur[6];
  bit m_en;

  function automatic int mx(int f, int hs);
    if (f == 0) return 2;
    if (f == 1) return (hs == 2) ? 3 : 9;
    if (f == 2 || f == 4) return 5;
    return 9;
  endfunction

  // k: bit0 mode, bit1 inc, bit2 ok, bit3 alarm
  task automatic model_key(input logic [3:0] k);
    int m;
    if (k[3]) m_en = !m_en;
    if (k[2]) begin
      if (m_st == 1) begin
        m_set = m_ed;
        m_strobes++;
      end else if (m_st == 2) begin
        for (int i = 0; i < 4; i++)
          m_alm[i] = m_ed[i];
      end
      m_st = 0;
      m_f  = 0;
    end else if (k[0]) begin
      if (m_st == 0) begin
        m_st = 1;
        m_f  = 0;
        for (int i = 0; i < 6; i++) begin
          m = mx(i, m_ed[0]);
          m_ed[i] = (m_cur[i] > m) ? m : m_cur[i];
        end
      end else if (m_st == 1 && m_f == 5) begin
        m_st = 2;
        m_f  = 0;
        for (int i = 0; i < 4; i++)
          m_ed[i] = m_alm[i];
      end else if (m_st == 2 && m_f == 3) begin
        m_st = 0;
        m_f  = 0;
      end else begin
        m_f++;
      end
    end else if (k[1] && m_st != 0) begin
      m = mx(m_f, m_ed[0]);
      m_ed[m_f] = (m_ed[m_f] >= m) ? 0 : m_ed[m_f] + 1;
      if (m_f == 0 && m_ed[0] == 2 && m_ed[1] > 3)
        m_ed[1] = 3;
    end
  endtask

  function automatic logic [23:0] exp_set();
    logic [23:0] r = '0;
    for (int i = 0; i < 6; i++)
      r = (r << 4) | 24'(m_set[i]);
    return r;
  endfunction

  function automatic logic [15:0] exp_alm();
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      r = (r << 4) | 16'(m_alm[i]);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_keys(input logic [3:0] k);
    {key_alarm_n, key_ok_n, key_inc_n, key_mode_n} = ~k;
  endtask

  task automatic press(input logic [3:0] k);
    drive_keys(k);
    tick(DEB + 4 + int'($urandom_range(0, 3)));
    drive_keys(4'h0);
    tick(DEB + 6 + int'($urandom_range(0, 3)));
    model_key(k);
  endtask

  task automatic drive_cur(input int h1, h0,
                           input int m1, m0,
                           input int s1, s0);
    m_cur[0] = h1; m_cur[1] = h0;
    m_cur[2] = m1; m_cur[3] = m0;
    m_cur[4] = s1; m_cur[5] = s0;
    cur_hour_shi = 4'(h1); cur_hour_ge = 4'(h0);
    cur_min_shi  = 4'(m1); cur_min_ge  = 4'(m0);
    cur_sec_shi  = 4'(s1); cur_sec_ge  = 4'(s0);
  endtask

  task automatic check_all(input string t);
    chk({t, "/set"}, 32'(got_set), 32'(exp_set()));
    chk({t, "/alm"}, 32'(got_alm), 32'(exp_alm()));
    chk({t, "/en"}, 32'(clock_en), 32'(m_en));
    chk({t, "/editing"}, 32'(editing),
        32'(m_st != 0));
    chk({t, "/edit_alarm"}, 32'(edit_alarm),
        32'(m_st == 2));
    chk({t, "/field"}, 32'(edit_field), 32'(m_f));
    chk({t, "/strobes"}, 32'(strobes),
        32'(m_strobes));
    chk({t, "/strobe_width"}, 32'(dbl), 32'(0));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] k;
    rst = 1'b1;
    drive_keys(4'h0);
    m_st = 0; m_f = 0; m_en = 0; m_strobes = 0;
    for (int i = 0; i < 6; i++) begin
      m_ed[i] = 0; m_set[i] = 0;
    end
    for (int i = 0; i < 4; i++) m_alm[i] = 0;
    drive_cur(0, 0, 0, 0, 0, 0);
    tick(3);
    rst = 1'b0;
    tick(50);
    check_all("reset");

    drive_cur(1, 2, 3, 4, 5, 6);
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    check_all("t22");
    chk("t22_hshi", 32'(set_hour_shi), 32'd2);
    chk("t22_hge", 32'(set_hour_ge), 32'd2);
    chk("t22_at_strobe", 32'(strobe_set),
        32'h223456);
    chk("t22_pre_strobe", 32'(strobe_pre), 32'h0);

    drive_cur(1, 9, 0, 0, 0, 0);
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    check_all("t23");
    chk("t23_set", 32'(got_set), 32'h230000);
    chk("t23_pre_strobe", 32'(strobe_pre),
        32'h223456);

    repeat (7) press(4'b0001);
    check_all("alarm_entry");
    press(4'b0001);
    repeat (3) press(4'b0010);
    press(4'b0100);
    check_all("alarm_commit");
    chk("alarm_val", 32'(got_alm), 32'h0300);

    key_mode_n = 1'b0;
    n = 0;
    while (editing !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk("tmo_enter", 32'(editing), 32'd1);
    key_mode_n = 1'b1;
    n = 0;
    while (editing === 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    model_key(4'b0001);
    m_st = 0;
    m_f  = 0;
    tick(DEB + 6);
    check_all("timeout");

    key_mode_n = 1'b0;
    tick(3);
    key_mode_n = 1'b1;
    tick(DEB + 10);
    check_all("glitch");

    drive_cur(0, 8, 5, 9, 4, 7);
    press(4'b0001);
    press(4'b0110);
    check_all("ok_inc");
    chk("ok_inc_set", 32'(got_set), 32'h085947);

    press(4'b1000);
    chk("alarm_on", 32'(clock_en), 32'd1);
    press(4'b1000);
    chk("alarm_off", 32'(clock_en), 32'd0);

    for (int it = 0; it < 80; it++) begin
      if (m_st == 0 && $urandom_range(0, 1) == 1)
        drive_cur(int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
      n = int'($urandom_range(0, 9));
      if (n < 4) k = 4'b0001;
      else if (n < 7) k = 4'b0010;
      else if (n == 7) k = 4'b0100;
      else if (n == 8) k = 4'b1000;
      else k = 4'($urandom_range(1, 15));
      press(k);
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, errs);
    $finish;
  end

endmodule
